// File: rtl/dut_pkg.sv
// Shared constants and state encoding for the
// program-3 signed multiply engine.
package dut_pkg;

  localparam int NUM_PAIRS = 16;
  localparam int OPND_BASE = 0;
  localparam int PROD_BASE = 64;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    LOAD,
    MUL,
    STORE,
    DONE
  } state_t;

endpackage

// File: rtl/data_mem.sv
// Byte-wide single-port data memory:
// synchronous write, combinational read, no reset.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] core [DEPTH];

  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end

  assign rdata = core[addr];

endmodule

// File: rtl/dut.sv
// Program-3 engine: 16 signed 16x16 products,
// operands and results kept in the local data memory.
module dut
  import dut_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  cyc_q, cyc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] mc_q, mc_d;
  logic [31:0] acc_q, acc_d;
  logic        done_q, done_d;

  logic        we;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [5:0]  off;
  logic [31:0] opnd_nx;

  data_mem #(
    .DEPTH(MEM_DEPTH),
    .AW   (8)
  ) dm (
    .clk  (clk),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata)
  );

  assign off     = {cnt_q[3:0], cyc_q[1:0]};
  assign opnd_nx = {opnd_q[23:0], rdata};

  always_comb begin
    if (state_q == STORE)
      addr = 8'(PROD_BASE) + {2'b00, off};
    else
      addr = 8'(OPND_BASE) + {2'b00, off};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    opnd_d  = opnd_q;
    mc_d    = mc_q;
    acc_d   = acc_q;
    we      = 1'b0;
    wdata   = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = ARMED;
      end
      ARMED: begin
        if (!start) begin
          state_d = LOAD;
          cnt_d   = 5'd0;
          cyc_d   = 4'd0;
        end
      end
      LOAD: begin
        // bytes arrive as {a_hi, a_lo, b_hi, b_lo}
        opnd_d = opnd_nx;
        cyc_d  = cyc_q + 4'd1;
        if (cyc_q == 4'd3) begin
          state_d = MUL;
          cyc_d   = 4'd0;
          mc_d    = {{16{opnd_nx[31]}}, opnd_nx[31:16]};
          acc_d   = 32'd0;
        end
      end
      MUL: begin
        // bit 15 of the multiplier carries negative weight
        if (opnd_q[0]) begin
          if (cyc_q == 4'd15) acc_d = acc_q - mc_q;
          else                acc_d = acc_q + mc_q;
        end
        mc_d   = mc_q << 1;
        opnd_d = opnd_q >> 1;
        cyc_d  = cyc_q + 4'd1;
        if (cyc_q == 4'd15) begin
          state_d = STORE;
          cyc_d   = 4'd0;
        end
      end
      STORE: begin
        we = 1'b1;
        case (cyc_q[1:0])
          2'd0:    wdata = acc_q[31:24];
          2'd1:    wdata = acc_q[23:16];
          2'd2:    wdata = acc_q[15:8];
          default: wdata = acc_q[7:0];
        endcase
        cyc_d = cyc_q + 4'd1;
        if (cyc_q == 4'd3) begin
          cyc_d = 4'd0;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(NUM_PAIRS - 1))
            state_d = DONE;
          else
            state_d = LOAD;
        end
      end
      DONE: begin
        if (start) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      cyc_q   <= 4'd0;
      opnd_q  <= 32'd0;
      mc_q    <= 32'd0;
      acc_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      opnd_q  <= opnd_d;
      mc_q    <= mc_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_dut.sv
// Randomised bench for the program-3 multiply engine
// against a plain-arithmetic product model.
module tb_dut;
  import dut_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b1;
  logic done;

  int total = 0;
  int bad = 0;
  int base_cycles = 0;

  logic [15:0] op [32];
  logic [7:0]  snap [256];

  dut u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++)
      u_dut.dm.core[i] = 8'($urandom);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 32; i++)
      op[i] = 16'($urandom);
  endtask

  task automatic put_ops();
    for (int i = 0; i < 32; i++) begin
      u_dut.dm.core[2*i]   = op[i][15:8];
      u_dut.dm.core[2*i+1] = op[i][7:0];
    end
    for (int i = 0; i < 256; i++)
      snap[i] = u_dut.dm.core[i];
  endtask

  function automatic logic [31:0] model(int k);
    longint a, b, p;
    a = longint'($signed(op[2*k]));
    b = longint'($signed(op[2*k+1]));
    p = a * b;
    return p[31:0];
  endfunction

  function automatic logic [31:0] got(int k);
    int b;
    b = PROD_BASE + 4 * k;
    return {u_dut.dm.core[b], u_dut.dm.core[b+1],
            u_dut.dm.core[b+2], u_dut.dm.core[b+3]};
  endfunction

  function automatic int outside_diffs();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++)
      if ((i < 64 || i > 127) && u_dut.dm.core[i] !== snap[i])
        n++;
    return n;
  endfunction

  task automatic run(input int glitch_at, output int cyc,
                     output logic ok);
    start = 1'b0;
    cyc = 0;
    ok = 1'b0;
    while (cyc < 450 && !ok) begin
      tick();
      cyc++;
      if (cyc == glitch_at) start = 1'b1;
      else if (cyc == glitch_at + 1) start = 1'b0;
      if (done === 1'b1) ok = 1'b1;
    end
    total++;
    if (!ok || cyc > 401) begin
      bad++;
      $display("FAIL done_latency: cycles=%0d ok=%0b need<=401",
               cyc, ok);
    end
  endtask

  task automatic check_products(input string tag);
    for (int k = 0; k < NUM_PAIRS; k++) begin
      total++;
      if (got(k) !== model(k)) begin
        bad++;
        $display("FAIL %s prod[%0d]: got %h want %h",
                 tag, k, got(k), model(k));
      end
    end
  endtask

  task automatic rearm();
    start = 1'b1;
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL rearm_done: got %b want 0", done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    total++;
    if (u_dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d",
               u_dut.state_q, IDLE);
    end
    total++;
    if (u_dut.cnt_q !== 5'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", u_dut.cnt_q);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (u_dut.state_q !== ARMED || done !== 1'b0) begin
      bad++;
      $display("FAIL arm_after_reset: state %0d done %b want %0d/0",
               u_dut.state_q, done, ARMED);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic ok;
    fill_random();
    rand_ops();
    put_ops();
    run(-5, cyc, ok);
    base_cycles = cyc;
    check_products("random");
    total++;
    if (outside_diffs() != 0) begin
      bad++;
      $display("FAIL random_outside: %0d bytes changed want 0",
               outside_diffs());
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (done !== 1'b1) begin
        bad++;
        $display("FAIL done_hold[%0d]: got %b want 1", i, done);
      end
    end
  endtask

  task automatic test_corners();
    int cyc;
    logic ok;
    logic [31:0] want [5];
    want[0] = 32'h40000000;
    want[1] = 32'hC0008000;
    want[2] = 32'h3FFF0001;
    want[3] = 32'h00000001;
    want[4] = 32'h00000000;
    rearm();
    rand_ops();
    op[1] = 16'h8000; op[0] = 16'h8000;
    op[3] = 16'h7FFF; op[2] = 16'h8000;
    op[5] = 16'h7FFF; op[4] = 16'h7FFF;
    op[7] = 16'hFFFF; op[6] = 16'hFFFF;
    op[9] = 16'h0000; op[8] = 16'(-12345);
    put_ops();
    run(-5, cyc, ok);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (got(k) !== want[k]) begin
        bad++;
        $display("FAIL corner[%0d]: got %h want %h",
                 k, got(k), want[k]);
      end
    end
    check_products("corner");
  endtask

  task automatic test_rerun();
    int cyc;
    logic ok;
    rearm();
    rand_ops();
    put_ops();
    run(-5, cyc, ok);
    check_products("rerun");
    total++;
    if (outside_diffs() != 0) begin
      bad++;
      $display("FAIL rerun_outside: %0d bytes changed want 0",
               outside_diffs());
    end
  endtask

  task automatic test_reset_mid();
    int cyc, n, diffs;
    logic ok;
    rearm();
    rand_ops();
    put_ops();
    start = 1'b0;
    n = 0;
    while (n < 300 &&
           !(u_dut.state_q == MUL && u_dut.cnt_q == 5'd5)) begin
      tick();
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL mid_reach: pair5 MUL not reached in %0d", n);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || u_dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL mid_reset: done %b state %0d want 0/%0d",
               done, u_dut.state_q, IDLE);
    end
    diffs = 0;
    for (int i = 0; i < 64; i++)
      if (u_dut.dm.core[i] !== snap[i]) diffs++;
    total++;
    if (diffs != 0) begin
      bad++;
      $display("FAIL mid_operands: %0d bytes changed want 0", diffs);
    end
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    tick();
    run(-5, cyc, ok);
    check_products("after_reset");
  endtask

  task automatic test_glitch();
    int cyc;
    logic ok;
    rearm();
    rand_ops();
    put_ops();
    run(100, cyc, ok);
    total++;
    if (cyc != base_cycles) begin
      bad++;
      $display("FAIL glitch_sched: cycles %0d want %0d",
               cyc, base_cycles);
    end
    check_products("glitch");
  endtask

  initial begin
    test_reset();
    test_random();
    test_corners();
    test_rerun();
    test_reset_mid();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
